disk_uc_fifo: RTL and testbench
===============================

Name: disk_uc_fifo

Overview:
Next-generation disk-to-micro-controller bridge. Supports up to 8 drives and contains the two data FIFOs the first-generation block left unconnected. Sits between the Q-bus disk controller front end and the internal micro-controller bus, entirely in the qclk domain. The block handles command hand-off and interrupts, buffers sector data in both directions, returns completion status, and holds the configuration registers.

Parameters:
uDEV, 0, device slot; UBASE = 8*uDEV.
NDRIVES, 8, drives supported, range 1..8.
FIFO_AW, 8, FIFO address width; depth = 2**FIFO_AW words of 16 bits each.
DEFAULT_ADDR, 0, reset value of io_addr_base.
DEFAULT_INT_VEC, 0, reset value of int_vec.
DEFAULT_INT_PRI, 0, reset value of int_priority.

Ports:
qclk  in  1  sole clock.
init  in  1  reset; synchronous, active-high.
uADDR  in  16  micro-controller bus address.
uDATA  inout  16  micro-controller bus data; driven only during a decoded read.
uWRITE  in  1  1 = write, 0 = read.
uSTB  in  1  access strobe; a bus access completes on a qclk edge with uSTB=1 and uWAIT=0.
uWAIT  out  1  stall (wired-OR); combinational.
uINTERRUPT  out  1  interrupt to the micro-controller.
io_addr_base  out  13  configuration.
int_vec  out  9  configuration.
int_priority  out  2  configuration.
mode  out  2  configuration.
loaded  out  NDRIVES  per-drive "pack loaded".
write_protect  out  NDRIVES  per-drive write protect.
cmd_valid  in  1  command offer from the controller.
cmd_ready  out  1  block accepts the command.
cmd  in  3  command code.
cmd_write  in  1  command writes the disk.
drive_select  in  3  target drive.
lba  in  32  target block address.
rd_data  out  16  disk-read data to the controller.
rd_valid  out  1  rd_data holds a word.
rd_ready  in  1  controller takes the word.
wr_data  in  16  disk-write data from the controller.
wr_valid  in  1  wr_data holds a word.
wr_ready  out  1  block accepts the word.
done  out  1  one-cycle completion pulse.
done_status  out  8  completion status; valid while done=1.

Behaviour:
- Register map, offset from UBASE:
  - 0 CMD (R): {9'b0, drive, 1'b0, cmd}. Reading it clears uINTERRUPT.
  - 1 DA_LOW (R): lba[15:0].
  - 2 DA_HI (R): lba[31:16].
  - 3 FIFO: R pops the write FIFO; W pushes the read FIFO.
  - 4 ADDR (W): io_addr_base <= uDATA[12:0].
  - 5 INT (W): {mode, int_priority, int_vec} <= {uDATA[15:14], uDATA[10:0]}.
  - 6 STAT (W): write_protect <= uDATA[8+:NDRIVES]; loaded <= uDATA[0+:NDRIVES].
  - 7 DONE (W): ends the command; status = uDATA[7:0].
- Undecoded reads: uDATA stays Z.
- cmd, drive and lba are latched on command accept; registers return the latched values.
- Reset (init=1 at an edge):
  - configuration outputs go to their defaults; mode=0; loaded=0; write_protect=0.
  - both FIFOs are emptied; state=IDLE; uINTERRUPT=0; done=0; done_status=0; cmd_ready=0 in that cycle.
  - While init=1, uWAIT=1.
  - Reset mid-command abandons the command without a done pulse.
- uWAIT = init | (uSTB & offset 3 & uWRITE & read FIFO full) | (uSTB & offset 3 & !uWRITE & write FIFO empty).
  - Full/empty are taken from the current count; a same-cycle controller pop or push does not release the stall until the next edge.
- FSM:
  - IDLE: cmd_ready=1. On cmd_valid, latch the command, then check:
    - mode==0 gives status 8'h03;
    - drive_select>=NDRIVES or !loaded[drive] gives 8'h01;
    - cmd_write & write_protect[drive] gives 8'h02.
    - Any failure goes to COMPLETE with no interrupt. Otherwise go to PEND and set uINTERRUPT the next cycle.
  - PEND: wait for the CMD read, then go to XFER.
  - XFER: FIFOs are active. A DONE write latches the status and goes to COMPLETE.
  - COMPLETE: done=1 for exactly one cycle; both FIFOs flushed; go to IDLE.
- A DONE write in IDLE or PEND: status is latched and the block goes to COMPLETE. In PEND, uINTERRUPT is also cleared.
- Read FIFO (uc to controller):
  - First-word-fall-through: rd_valid = !empty; a pop occurs on rd_valid & rd_ready.
  - Data appears on rd_data 1 cycle after the push into an empty FIFO.
- Write FIFO (controller to uc):
  - wr_ready = !full & state==XFER.
  - A uc read of FIFO returns the head word combinationally and pops it at the completing edge.
- Simultaneous push and pop on a non-empty, non-full FIFO: the count is unchanged. Pointers wrap modulo the depth; the count is FIFO_AW+1 bits.

Optional Feature:
QSIC_FIFO_LEVEL_EN.
- Defined: a read of offset 4 returns {read-FIFO count[7:0], write-FIFO count[7:0]}, each saturated at 255.
- Not defined: reads of offset 4 leave uDATA at Z. The logic is absent.

Test Plan:
1. Hold init for 2 cycles, then release -> uWAIT=1 during init then 0; io_addr_base=DEFAULT_ADDR; mode=0; cmd_ready=1.
2. Write INT=16'h4000 and STAT=16'h0001; offer cmd=3, drive=0, lba=32'h00012345 -> uINTERRUPT=1; CMD reads 16'h0003; DA_HI reads 16'h0001 and DA_LOW 16'h2345; uINTERRUPT=0 after the CMD read.
3. In XFER, push 2**FIFO_AW words via FIFO writes with rd_ready=0 -> the next write stalls (uWAIT=1); a single rd_ready pop releases it on the following cycle; rd_data order equals push order.
4. cmd_write=1 to drive 0 with STAT=16'h0101 -> no interrupt; done=1 for 1 cycle with done_status=8'h02. drive_select=5 with NDRIVES=4 -> 8'h01.
5. Controller writes 3 words; uc reads FIFO 4 times -> the 4th read stalls until wr_valid delivers a word; DONE write 16'h0000 -> done pulse with status 8'h00, FIFOs empty.
6. Assert init during XFER with 10 words buffered -> no done pulse; rd_valid=0; state=IDLE after release.

Source files
------------

// File: rtl/disk_uc_fifo.sv
// Disk-controller to micro-controller bridge: command hand-off, interrupt, two sector FIFOs, config regs.
// Optional build macro QSIC_FIFO_LEVEL_EN adds a FIFO level read at register offset 4.
module disk_uc_fifo #(
    parameter int          uDEV            = 0,
    parameter int          NDRIVES         = 8,
    parameter int          FIFO_AW         = 8,
    parameter logic [12:0] DEFAULT_ADDR    = 13'd0,
    parameter logic [8:0]  DEFAULT_INT_VEC = 9'd0,
    parameter logic [1:0]  DEFAULT_INT_PRI = 2'd0
) (
    input  logic               qclk,
    input  logic               init,
    input  logic [15:0]        uADDR,
    inout  wire  [15:0]        uDATA,
    input  logic               uWRITE,
    input  logic               uSTB,
    output logic               uWAIT,
    output logic               uINTERRUPT,
    output logic [12:0]        io_addr_base,
    output logic [8:0]         int_vec,
    output logic [1:0]         int_priority,
    output logic [1:0]         mode,
    output logic [NDRIVES-1:0] loaded,
    output logic [NDRIVES-1:0] write_protect,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [2:0]         cmd,
    input  logic               cmd_write,
    input  logic [2:0]         drive_select,
    input  logic [31:0]        lba,
    output logic [15:0]        rd_data,
    output logic               rd_valid,
    input  logic               rd_ready,
    input  logic [15:0]        wr_data,
    input  logic               wr_valid,
    output logic               wr_ready,
    output logic               done,
    output logic [7:0]         done_status
);
    localparam int          DEPTH = 1 << FIFO_AW;
    localparam logic [12:0] UPAGE = 13'(uDEV);

    typedef enum logic [1:0] {IDLE, PEND, XFER, COMPLETE} state_t;
    state_t state;

    logic [2:0]  cmd_q, drv_q;
    logic [31:0] lba_q;
    logic        hit, acc, wr_acc, rd_acc, done_wr, cmd_rd;
    logic [2:0]  off;

    assign hit     = uADDR[15:3] == UPAGE;
    assign off     = uADDR[2:0];
    assign acc     = uSTB & ~uWAIT & hit;
    assign wr_acc  = acc & uWRITE;
    assign rd_acc  = acc & ~uWRITE;
    assign done_wr = wr_acc & (off == 3'd7);
    assign cmd_rd  = rd_acc & (off == 3'd0);

    logic [15:0]        rf_mem [DEPTH];
    logic [15:0]        wf_mem [DEPTH];
    logic [FIFO_AW-1:0] rf_wp, rf_rp, wf_wp, wf_rp;
    logic [FIFO_AW:0]   rf_cnt, wf_cnt;
    logic               rf_full, wf_full, wf_empty, rf_push, rf_pop, wf_push, wf_pop, flush;

    assign rf_full  = rf_cnt == (FIFO_AW+1)'(DEPTH);
    assign wf_full  = wf_cnt == (FIFO_AW+1)'(DEPTH);
    assign wf_empty = wf_cnt == '0;
    assign rd_valid = rf_cnt != '0;
    assign rd_data  = rf_mem[rf_rp];
    assign wr_ready = ~wf_full & (state == XFER);
    assign rf_push  = wr_acc & (off == 3'd3) & (state == XFER);
    assign rf_pop   = rd_valid & rd_ready;
    assign wf_push  = wr_valid & wr_ready;
    assign wf_pop   = rd_acc & (off == 3'd3);
    assign flush    = init | (state == COMPLETE);

    // Stall uses the registered counts only, so a same-cycle opposite-side transfer releases it one edge later.
    assign uWAIT = init | (uSTB & hit & (off == 3'd3) & (uWRITE ? rf_full : wf_empty));

    always_ff @(posedge qclk) begin
        if (rf_push) rf_mem[rf_wp] <= uDATA;
        if (wf_push) wf_mem[wf_wp] <= wr_data;
    end

    always_ff @(posedge qclk) begin
        if (flush) begin
            rf_wp <= '0; rf_rp <= '0; rf_cnt <= '0;
            wf_wp <= '0; wf_rp <= '0; wf_cnt <= '0;
        end else begin
            if (rf_push) rf_wp <= rf_wp + 1'b1;
            if (rf_pop)  rf_rp <= rf_rp + 1'b1;
            if (wf_push) wf_wp <= wf_wp + 1'b1;
            if (wf_pop)  wf_rp <= wf_rp + 1'b1;
            rf_cnt <= rf_cnt + (FIFO_AW+1)'(rf_push) - (FIFO_AW+1)'(rf_pop);
            wf_cnt <= wf_cnt + (FIFO_AW+1)'(wf_push) - (FIFO_AW+1)'(wf_pop);
        end
    end

`ifdef QSIC_FIFO_LEVEL_EN
    function automatic logic [7:0] sat8(input logic [FIFO_AW:0] c);
        logic [31:0] v;
        v = 32'(c);
        return (v > 32'd255) ? 8'hFF : v[7:0];
    endfunction
`endif

    logic [15:0] rdata;
    logic        rdec;
    always_comb begin
        rdata = '0;
        rdec  = 1'b1;
        case (off)
            3'd0: rdata = {9'b0, drv_q, 1'b0, cmd_q};
            3'd1: rdata = lba_q[15:0];
            3'd2: rdata = lba_q[31:16];
            3'd3: rdata = wf_mem[wf_rp];
`ifdef QSIC_FIFO_LEVEL_EN
            3'd4: rdata = {sat8(rf_cnt), sat8(wf_cnt)};
`endif
            default: rdec = 1'b0;
        endcase
    end
    assign uDATA = (uSTB & ~uWRITE & hit & rdec) ? rdata : 16'hzzzz;

    // Drives above NDRIVES read as unloaded through the zero-extended vectors.
    logic [7:0] ld8, wp8, chk_st;
    assign ld8 = 8'(loaded);
    assign wp8 = 8'(write_protect);
    always_comb begin
        chk_st = 8'h00;
        if (mode == 2'd0)                                        chk_st = 8'h03;
        else if (32'(drive_select) >= NDRIVES || !ld8[drive_select]) chk_st = 8'h01;
        else if (cmd_write && wp8[drive_select])                 chk_st = 8'h02;
    end

    always_ff @(posedge qclk) begin
        if (init) begin
            io_addr_base  <= DEFAULT_ADDR;
            int_vec       <= DEFAULT_INT_VEC;
            int_priority  <= DEFAULT_INT_PRI;
            mode          <= 2'd0;
            loaded        <= '0;
            write_protect <= '0;
            state         <= IDLE;
            uINTERRUPT    <= 1'b0;
            done          <= 1'b0;
            done_status   <= 8'h00;
            cmd_ready     <= 1'b0;
            cmd_q         <= '0;
            drv_q         <= '0;
            lba_q         <= '0;
        end else begin
            done <= 1'b0;
            if (wr_acc) begin
                case (off)
                    3'd4: io_addr_base <= uDATA[12:0];
                    3'd5: {mode, int_priority, int_vec} <= {uDATA[15:14], uDATA[10:0]};
                    3'd6: begin
                        write_protect <= uDATA[8 +: NDRIVES];
                        loaded        <= uDATA[0 +: NDRIVES];
                    end
                    default: ;
                endcase
            end
            if (cmd_rd) uINTERRUPT <= 1'b0;
            case (state)
                IDLE: begin
                    if (cmd_ready && cmd_valid) begin
                        cmd_q     <= cmd;
                        drv_q     <= drive_select;
                        lba_q     <= lba;
                        cmd_ready <= 1'b0;
                        if (chk_st != 8'h00) begin
                            state       <= COMPLETE;
                            done        <= 1'b1;
                            done_status <= chk_st;
                        end else begin
                            state      <= PEND;
                            uINTERRUPT <= 1'b1;
                        end
                    end else if (done_wr) begin
                        state       <= COMPLETE;
                        done        <= 1'b1;
                        done_status <= uDATA[7:0];
                        cmd_ready   <= 1'b0;
                    end else begin
                        cmd_ready <= 1'b1;
                    end
                end
                PEND: begin
                    if (done_wr) begin
                        state       <= COMPLETE;
                        done        <= 1'b1;
                        done_status <= uDATA[7:0];
                        uINTERRUPT  <= 1'b0;
                    end else if (cmd_rd) begin
                        state <= XFER;
                    end
                end
                XFER: begin
                    if (done_wr) begin
                        state       <= COMPLETE;
                        done        <= 1'b1;
                        done_status <= uDATA[7:0];
                    end
                end
                COMPLETE: begin
                    state     <= IDLE;
                    cmd_ready <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_disk_uc_fifo.sv
// Randomized bench for disk_uc_fifo; queue-based FIFO model and a rule-based status model.
module tb_disk_uc_fifo;
    localparam int          NDRV  = 4;
    localparam int          AW    = 4;
    localparam int          DEPTH = 1 << AW;
    localparam logic [15:0] BASE  = 16'h0008;

    logic        qclk = 1'b0;
    logic        init, uWRITE, uSTB, cmd_valid, cmd_write, rd_ready, wr_valid, tb_drv;
    logic [15:0] uADDR, tb_dq, wr_data;
    logic [2:0]  cmd, drive_select;
    logic [31:0] lba;
    wire  [15:0] uDATA;
    wire         uWAIT, uINTERRUPT, cmd_ready, rd_valid, wr_ready, done;
    wire  [12:0] io_addr_base;
    wire  [8:0]  int_vec;
    wire  [1:0]  int_priority, mode;
    wire  [NDRV-1:0] loaded, write_protect;
    wire  [15:0] rd_data;
    wire  [7:0]  done_status;

    assign uDATA = tb_drv ? tb_dq : 16'hzzzz;
    always #5 qclk = ~qclk;

    disk_uc_fifo #(.uDEV(1), .NDRIVES(NDRV), .FIFO_AW(AW), .DEFAULT_ADDR(13'h0155),
                   .DEFAULT_INT_VEC(9'h0A5), .DEFAULT_INT_PRI(2'd2)) dut (
        .qclk(qclk), .init(init), .uADDR(uADDR), .uDATA(uDATA), .uWRITE(uWRITE), .uSTB(uSTB),
        .uWAIT(uWAIT), .uINTERRUPT(uINTERRUPT), .io_addr_base(io_addr_base), .int_vec(int_vec),
        .int_priority(int_priority), .mode(mode), .loaded(loaded), .write_protect(write_protect),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd(cmd), .cmd_write(cmd_write),
        .drive_select(drive_select), .lba(lba), .rd_data(rd_data), .rd_valid(rd_valid),
        .rd_ready(rd_ready), .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .done(done), .done_status(done_status));

    int          nvec = 0, nerr = 0;
    logic [15:0] rq[$], wq[$];
    logic [15:0] v, w;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge qclk); #1;
    endtask

    // All bus/command tasks start and end 1 time unit after a rising edge.
    task automatic bus_wr(input logic [2:0] off, input logic [15:0] d);
        int n = 0;
        uADDR = BASE + 16'(off); uWRITE = 1'b1; uSTB = 1'b1; tb_dq = d; tb_drv = 1'b1;
        @(negedge qclk);
        while (uWAIT && n < 200) begin n++; @(negedge qclk); end
        chk("wr_stall_bound", uWAIT, 0);
        step();
        uSTB = 1'b0; tb_drv = 1'b0;
    endtask

    task automatic bus_rd(input logic [2:0] off, output logic [15:0] d);
        int n = 0;
        uADDR = BASE + 16'(off); uWRITE = 1'b0; uSTB = 1'b1;
        @(negedge qclk);
        while (uWAIT && n < 200) begin n++; @(negedge qclk); end
        chk("rd_stall_bound", uWAIT, 0);
        d = uDATA;
        step();
        uSTB = 1'b0;
    endtask

    task automatic issue(input logic [2:0] c, input logic wrt, input logic [2:0] d, input logic [31:0] l);
        int n = 0;
        cmd = c; cmd_write = wrt; drive_select = d; lba = l; cmd_valid = 1'b1;
        @(negedge qclk);
        while (!cmd_ready && n < 20) begin n++; @(negedge qclk); end
        chk("cmd_ready", cmd_ready, 1);
        step();
        cmd_valid = 1'b0;
    endtask

    task automatic expect_done(input logic [7:0] st);
        int n = 0;
        @(negedge qclk);
        while (!done && n < 20) begin n++; @(negedge qclk); end
        chk("done_seen", done, 1);
        chk("done_status", done_status, st);
        chk("no_irq", uINTERRUPT, 0);
        @(negedge qclk);
        chk("done_one_cycle", done, 0);
        chk("idle_ready", cmd_ready, 1);
        step();
    endtask

    task automatic start_xfer(input logic [2:0] c, input logic [2:0] d, input logic [31:0] l);
        logic [15:0] r;
        @(negedge qclk);
        chk("irq_set", uINTERRUPT, 1);
        step();
        bus_rd(3'd0, r); chk("cmd_reg", r, {9'b0, d, 1'b0, c});
        chk("irq_clr", uINTERRUPT, 0);
        bus_rd(3'd2, r); chk("da_hi", r, l[31:16]);
        bus_rd(3'd1, r); chk("da_low", r, l[15:0]);
    endtask

    task automatic drain();
        int n = 0;
        while (rq.size() > 0 && n < 500) begin
            rd_ready = 1'($urandom_range(0, 1));
            @(negedge qclk);
            chk("rd_valid", rd_valid, 1);
            if (rd_ready) begin
                chk("rd_data", rd_data, rq[0]);
                void'(rq.pop_front());
            end
            step();
            n++;
        end
        rd_ready = 1'b0;
        @(negedge qclk);
        chk("rd_empty", rd_valid, 0);
        step();
    endtask

    task automatic ctl_push(input int cnt);
        for (int i = 0; i < cnt; i++) begin
            int k;
            k = 0;
            wr_data = 16'($urandom); wr_valid = 1'b1;
            @(negedge qclk);
            while (!wr_ready && k < 50) begin k++; @(negedge qclk); end
            chk("wr_ready", wr_ready, 1);
            step();
            wq.push_back(wr_data);
        end
        wr_valid = 1'b0;
    endtask

    task automatic uc_pull(input int cnt);
        logic [15:0] r;
        for (int i = 0; i < cnt; i++) begin
            bus_rd(3'd3, r);
            chk("wf_data", r, wq[0]);
            void'(wq.pop_front());
        end
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        init = 1'b1; uSTB = 1'b0; uWRITE = 1'b0; uADDR = '0; tb_dq = '0; tb_drv = 1'b0;
        cmd_valid = 1'b0; cmd = '0; cmd_write = 1'b0; drive_select = '0; lba = '0;
        rd_ready = 1'b0; wr_valid = 1'b0; wr_data = '0;

        // reset
        repeat (2) begin
            @(negedge qclk);
            chk("wait_in_init", uWAIT, 1);
        end
        chk("cmd_ready_init", cmd_ready, 0);
        step();
        init = 1'b0;
        @(negedge qclk);
        chk("wait_released", uWAIT, 0);
        chk("addr_default", io_addr_base, 13'h0155);
        chk("vec_default", int_vec, 9'h0A5);
        chk("pri_default", int_priority, 2'd2);
        chk("mode_reset", mode, 0);
        chk("irq_reset", uINTERRUPT, 0);
        chk("rd_valid_reset", rd_valid, 0);
        step();
        @(negedge qclk);
        chk("cmd_ready_idle", cmd_ready, 1);
        step();

        // basic command hand-off
        bus_wr(3'd4, 16'h1ABC); chk("addr_wr", io_addr_base, 13'h1ABC);
        bus_wr(3'd5, 16'h4000); chk("mode_wr", mode, 1);
        bus_wr(3'd6, 16'h0001); chk("loaded_wr", loaded, 4'h1);
        issue(3'd3, 1'b0, 3'd0, 32'h0001_2345);
        start_xfer(3'd3, 3'd0, 32'h0001_2345);

        // read FIFO: fill-through, full stall, release one edge after a pop
        w = 16'($urandom);
        bus_wr(3'd3, w); rq.push_back(w);
        chk("fwft_valid", rd_valid, 1);
        chk("fwft_data", rd_data, w);
        for (int i = 1; i < DEPTH; i++) begin
            w = 16'($urandom);
            bus_wr(3'd3, w); rq.push_back(w);
        end
        w = 16'($urandom);
        uADDR = BASE + 16'd3; uWRITE = 1'b1; uSTB = 1'b1; tb_dq = w; tb_drv = 1'b1;
        @(negedge qclk);
        chk("full_stall", uWAIT, 1);
        step();
        rd_ready = 1'b1;
        @(negedge qclk);
        chk("stall_same_cycle", uWAIT, 1);
        chk("head_word", rd_data, rq[0]);
        step();
        void'(rq.pop_front());
        rd_ready = 1'b0;
        @(negedge qclk);
        chk("stall_released", uWAIT, 0);
        step();
        rq.push_back(w);
        uSTB = 1'b0; tb_drv = 1'b0;
        drain();

        // write FIFO: empty stall on the 4th read until a word arrives
        ctl_push(3);
        uc_pull(3);
        uADDR = BASE + 16'd3; uWRITE = 1'b0; uSTB = 1'b1;
        @(negedge qclk);
        chk("empty_stall", uWAIT, 1);
        step();
        w = 16'($urandom);
        wr_data = w; wr_valid = 1'b1;
        @(negedge qclk);
        chk("empty_same_cycle", uWAIT, 1);
        step();
        wr_valid = 1'b0;
        @(negedge qclk);
        chk("empty_released", uWAIT, 0);
        chk("late_word", uDATA, w);
        step();
        uSTB = 1'b0;
        bus_wr(3'd3, 16'hBEEF); bus_wr(3'd3, 16'hCAFE);
        ctl_push(2);
        bus_wr(3'd7, 16'h0000);
        expect_done(8'h00);
        chk("rf_flushed", rd_valid, 0);
        chk("wr_closed", wr_ready, 0);
        rq.delete(); wq.delete();

        // rejected commands
        bus_wr(3'd6, 16'h0101);
        issue(3'd1, 1'b1, 3'd0, 32'h0);      expect_done(8'h02);
        issue(3'd1, 1'b0, 3'd5, 32'h0);      expect_done(8'h01);
        issue(3'd1, 1'b0, 3'd2, 32'h0);      expect_done(8'h01);
        bus_wr(3'd5, 16'h0000);
        issue(3'd1, 1'b0, 3'd0, 32'h0);      expect_done(8'h03);

        // randomized commands against the status rules and FIFO queues
        for (int it = 0; it < 16; it++) begin
            logic [1:0]  m;
            logic [3:0]  ld, wp;
            logic [2:0]  c, d;
            logic        wrt;
            logic [31:0] l;
            logic [10:0] iv;
            logic [7:0]  st, exp;
            m = 2'($urandom); ld = 4'($urandom); wp = 4'($urandom);
            c = 3'($urandom); d = 3'($urandom_range(0, 5)); wrt = 1'($urandom);
            l = $urandom; iv = 11'($urandom); st = 8'($urandom);
            if (it % 2 == 0) begin m = 2'd1; ld = 4'hF; wp = 4'h0; d = 3'($urandom_range(0, 3)); end
            bus_wr(3'd5, {m, 3'b000, iv});
            chk("int_fields", {mode, int_priority, int_vec}, {m, iv});
            bus_wr(3'd6, {4'h0, wp, 4'h0, ld});
            chk("stat_fields", {write_protect, loaded}, {wp, ld});
            if (m == 2'd0)                         exp = 8'h03;
            else if (d >= 3'd4 || !ld[d[1:0]])    exp = 8'h01;
            else if (wrt && wp[d[1:0]])            exp = 8'h02;
            else                                   exp = 8'h00;
            issue(c, wrt, d, l);
            if (exp != 8'h00) begin
                expect_done(exp);
            end else begin
                start_xfer(c, d, l);
                for (int i = 0; i < $urandom_range(1, 6); i++) begin
                    w = 16'($urandom);
                    bus_wr(3'd3, w); rq.push_back(w);
                end
                drain();
                ctl_push($urandom_range(1, 5));
                uc_pull(wq.size());
                bus_wr(3'd7, {8'h00, st});
                expect_done(st);
            end
        end

        // reset in the middle of a transfer
        bus_wr(3'd5, 16'h4000); bus_wr(3'd6, 16'h0001);
        v = 16'($urandom);
        issue(3'd2, 1'b0, 3'd0, {16'h0, v});
        start_xfer(3'd2, 3'd0, {16'h0, v});
        for (int i = 0; i < 10; i++) bus_wr(3'd3, 16'($urandom));
        @(negedge qclk);
        chk("buffered", rd_valid, 1);
        step();
        init = 1'b1;
        repeat (2) begin
            @(negedge qclk);
            chk("no_done_in_reset", done, 0);
            step();
        end
        init = 1'b0;
        @(negedge qclk);
        chk("no_done_after_reset", done, 0);
        chk("rd_valid_after_reset", rd_valid, 0);
        chk("irq_after_reset", uINTERRUPT, 0);
        chk("wr_ready_after_reset", wr_ready, 0);
        step();
        @(negedge qclk);
        chk("idle_after_reset", cmd_ready, 1);
        step();
        issue(3'd1, 1'b0, 3'd0, 32'h0);
        expect_done(8'h03);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
